// File: rtl/lvds_tx_pkg.sv
// Shared types for the LVDS transmit framer.
// Sample pair layout, FSM states and beat slicing helper.
package lvds_tx_pkg;

  localparam int BEATS = 4;
  localparam int PH_W  = $clog2(BEATS);

  typedef struct packed {
    logic [11:0] i;
    logic [11:0] q;
  } iq_t;

  typedef enum logic {
    IDLE,
    RUN
  } tx_state_e;

  // MSB half first, I before Q
  function automatic logic [5:0] beat_of(
    input iq_t             s,
    input logic [PH_W-1:0] ph
  );
    logic [5:0] b;
    unique case (ph)
      PH_W'(0): b = s.i[11:6];
      PH_W'(1): b = s.i[5:0];
      PH_W'(2): b = s.q[11:6];
      default:  b = s.q[5:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lvds_tx_framer_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo #(
  parameter int W  = 24,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [W-1:0]  r_mem [2**AW];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == DEPTH);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rp];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/lvds_tx_framer.sv
// Transmit framer: buffers I/Q pairs and emits four 6-bit beats
// per pair with a 1,1,0,0 frame marker toward the LVDS output stage.
module lvds_tx_framer
  import lvds_tx_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int PRIME   = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             en,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [11:0]      s_i,
  input  logic [11:0]      s_q,
  output logic [5:0]       tx_d,
  output logic             tx_frame,
  output logic             active,
  output logic             underflow,
  output logic [CNT_W-1:0] underflow_cnt
);

  localparam logic [FIFO_AW:0] PRIME_C = PRIME[FIFO_AW:0];

  iq_t              w_head;
  logic             w_full;
  logic             w_empty;
  logic [FIFO_AW:0] w_count;
  logic             w_pop;
  logic             w_zero;
  logic             w_stop;
  tx_state_e        w_state_nx;

  tx_state_e        r_state;
  logic [PH_W-1:0]  r_phase;
  iq_t              r_hold;
  logic [5:0]       r_tx_d;
  logic             r_frame;
  logic             r_uf;
  logic [CNT_W-1:0] r_cnt;

  sync_fifo #(
    .W  (24),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_b (reset_b),
    .i_push  (s_valid),
    .i_wdata ({s_i, s_q}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign s_ready       = ~w_full;
  assign tx_d          = r_tx_d;
  assign tx_frame      = r_frame;
  assign active        = (r_state == RUN);
  assign underflow     = r_uf;
  assign underflow_cnt = r_cnt;

  // Phase 0 in RUN is the sample boundary where the next pair is chosen
  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_zero     = 1'b0;
    w_stop     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en && w_count >= PRIME_C) begin
          w_pop      = 1'b1;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        if (r_phase == '0) begin
          if (!en) begin
            w_stop     = 1'b1;
            w_state_nx = IDLE;
          end else if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_zero = 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_hold  <= '0;
      r_tx_d  <= '0;
      r_frame <= 1'b0;
      r_uf    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_uf    <= w_zero;
      if (w_zero && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      unique case (1'b1)
        w_pop: begin
          r_hold  <= w_head;
          r_tx_d  <= beat_of(w_head, '0);
          r_frame <= 1'b1;
          r_phase <= PH_W'(1);
        end
        w_zero: begin
          r_hold  <= '0;
          r_tx_d  <= '0;
          r_frame <= 1'b1;
          r_phase <= PH_W'(1);
        end
        w_stop: begin
          r_tx_d  <= '0;
          r_frame <= 1'b0;
          r_phase <= '0;
        end
        (r_state == RUN && r_phase != '0): begin
          r_tx_d  <= beat_of(r_hold, r_phase);
          r_frame <= ~r_phase[PH_W-1];
          r_phase <= r_phase + 1'b1;
        end
        default: begin
          r_tx_d  <= '0;
          r_frame <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Directed self-checking bench for lvds_tx_framer.
// PRIME=1, CNT_W=4 so saturation is reachable quickly.
module tb_lvds_tx_framer;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       en = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [11:0] s_i = '0;
  logic [11:0] s_q = '0;
  logic [5:0] tx_d;
  logic       tx_frame;
  logic       active;
  logic       underflow;
  logic [3:0] underflow_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [23:0] pats [16];

  always #5 clk = ~clk;

  lvds_tx_framer #(
    .FIFO_AW (4),
    .PRIME   (1),
    .CNT_W   (4)
  ) u_dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .en            (en),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_i           (s_i),
    .s_q           (s_q),
    .tx_d          (tx_d),
    .tx_frame      (tx_frame),
    .active        (active),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_beat(
    input logic [23:0] p,
    input int          ph
  );
    logic [11:0] i;
    logic [11:0] q;
    i = p[23:12];
    q = p[11:0];
    case (ph)
      0:       return {1'b1, i[11:6]};
      1:       return {1'b1, i[5:0]};
      2:       return {1'b0, q[11:6]};
      default: return {1'b0, q[5:0]};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    en      = 1'b0;
    s_valid = 1'b0;
    s_i     = '0;
    s_q     = '0;
    tick();
    @(negedge clk);
    reset_b = 1'b1;
    tick();
  endtask

  task automatic push_one(input logic [11:0] i, input logic [11:0] q);
    s_valid = 1'b1;
    s_i     = i;
    s_q     = q;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    logic [23:0] p;

    // reset values while held in reset
    reset_b = 1'b0;
    tick();
    check("rst_txd", tx_d, 6'h0);
    check("rst_frame", tx_frame, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_uf", underflow, 1'b0);
    check("rst_cnt", underflow_cnt, 4'h0);
    check("rst_ready", s_ready, 1'b1);

    // 1: single pair 0xABC/0x123
    do_reset();
    en = 1'b1;
    push_one(12'hABC, 12'h123);
    tick();
    check("t1_b0", {tx_frame, tx_d}, {1'b1, 6'h2A});
    check("t1_act", active, 1'b1);
    tick();
    check("t1_b1", {tx_frame, tx_d}, {1'b1, 6'h3C});
    tick();
    check("t1_b2", {tx_frame, tx_d}, {1'b0, 6'h04});
    tick();
    check("t1_b3", {tx_frame, tx_d}, {1'b0, 6'h23});
    en = 1'b0;
    tick();
    check("t1_idle", {active, tx_frame, tx_d}, 8'h00);
    check("t1_nouf", underflow, 1'b0);

    // 2: full FIFO drains as 64 gapless beats
    do_reset();
    for (int k = 0; k < 16; k++) begin
      check("t2_rdy_fill", s_ready, 1'b1);
      pats[k] = {12'(k*273 + 195), 12'(4000 - k*91)};
      push_one(pats[k][23:12], pats[k][11:0]);
    end
    check("t2_full", s_ready, 1'b0);
    en = 1'b1;
    for (int b = 0; b < 64; b++) begin
      tick();
      check($sformatf("t2_beat%0d", b), {tx_frame, tx_d},
            exp_beat(pats[b/4], b % 4));
      if (b == 0) check("t2_rdy_again", s_ready, 1'b1);
    end
    en = 1'b0;
    tick();
    check("t2_idle", {active, tx_frame, tx_d}, 8'h00);
    check("t2_cnt", underflow_cnt, 4'h0);

    // 3: one pair then zero-fill underflows
    do_reset();
    en = 1'b1;
    p = {12'h3F0, 12'h00F};
    push_one(p[23:12], p[11:0]);
    for (int b = 0; b < 4; b++) begin
      tick();
      check("t3_beat", {tx_frame, tx_d}, exp_beat(p, b));
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      check("t3_zero", {tx_frame, tx_d}, {(c % 4) < 2, 6'h0});
      check("t3_uf", underflow, (c % 4) == 0);
      check("t3_act", active, 1'b1);
    end
    check("t3_cnt", underflow_cnt, 4'd3);
    en = 1'b0;
    tick();
    check("t3_idle", {active, tx_frame, tx_d}, 8'h00);

    // 4: en drops at phase1, sample still completes
    do_reset();
    en = 1'b1;
    p = {12'h5A5, 12'hC3C};
    s_valid = 1'b1;
    s_i = p[23:12];
    s_q = p[11:0];
    tick();
    s_i = 12'h111;
    s_q = 12'h222;
    tick();
    s_valid = 1'b0;
    check("t4_b0", {tx_frame, tx_d}, exp_beat(p, 0));
    en = 1'b0;
    for (int b = 1; b < 4; b++) begin
      tick();
      check("t4_beat", {tx_frame, tx_d}, exp_beat(p, b));
    end
    tick();
    check("t4_idle", {active, tx_frame, tx_d}, 8'h00);
    check("t4_nouf", underflow, 1'b0);

    // 5: async reset at phase2
    do_reset();
    en = 1'b1;
    p = {12'hFFF, 12'h801};
    s_valid = 1'b1;
    s_i = p[23:12];
    s_q = p[11:0];
    tick();
    tick();
    s_valid = 1'b0;
    tick();
    check("t5_b1", {tx_frame, tx_d}, exp_beat(p, 1));
    #2;
    reset_b = 1'b0;
    #1;
    check("t5_async", {active, tx_frame, tx_d}, 8'h00);
    check("t5_ready", s_ready, 1'b1);
    @(negedge clk);
    reset_b = 1'b1;
    repeat (3) begin
      tick();
      check("t5_empty", {active, tx_frame, tx_d}, 8'h00);
    end
    en = 1'b0;

    // 6: counter saturates at 0xF, pulse continues
    do_reset();
    en = 1'b1;
    push_one(12'h00A, 12'h00B);
    tick();
    for (int u = 1; u <= 20; u++) begin
      repeat (4) tick();
      check("t6_uf", underflow, 1'b1);
      check("t6_cnt", underflow_cnt, (u > 15) ? 4'hF : 4'(u));
    end
    tick();
    check("t6_uf_low", underflow, 1'b0);
    en = 1'b0;
    repeat (3) tick();
    check("t6_idle", active, 1'b0);
    check("t6_hold", underflow_cnt, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
